// File: rtl/ram_dump_ctrl_pkg.sv
// Shared definitions for the RAM fill/dump sequencer: default widths, the
// default fill seed and the controller state encoding.
// Optional feature macro: RAM_DUMP_CKSUM_EN (appends a checksum byte to a dump).
package ram_dump_ctrl_pkg;

  localparam int         ADDR_W_DEF = 8;
  localparam int         DATA_W_DEF = 8;
  localparam int         RD_LAT_DEF = 1;
  localparam logic [7:0] SEED_DEF   = 8'h00;

  // CKSUM keeps its encoding in every build; it is only reachable when the
  // checksum feature is compiled in.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    RD_ADDR  = 3'd2,
    RD_WAIT  = 3'd3,
    TX_START = 3'd4,
    TX_WAIT  = 3'd5,
    CKSUM    = 3'd6
  } state_t;

endpackage

// File: rtl/ram_dump_ctrl_if.sv
// Bus bundle between the sequencer, the single-port RAM and the UART transmitter.
// master = sequencer side, slave = RAM/UART side.
interface ram_dump_ctrl_if
  import ram_dump_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;

  modport master (
    output ram_we, ram_addr, ram_wdata, tx_start, tx_data,
    input  ram_rdata, tx_done
  );

  modport slave (
    input  ram_we, ram_addr, ram_wdata, tx_start, tx_data,
    output ram_rdata, tx_done
  );

endinterface

// File: rtl/ram_dump_ctrl_key_edge.sv
// Rising-edge detector for a debounced key level: one-cycle pulse, one cycle
// after the level goes high.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // Track the previous level; reset loads the live level so a key already
  // held down during reset does not fire on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= level;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/ram_dump_ctrl.sv
// RAM fill/dump sequencer. key1 writes addr ^ SEED into every RAM location,
// key2 reads every location in order and hands each byte to the UART with a
// start/done handshake. Key edges arriving while busy are discarded.
// Optional feature macro: RAM_DUMP_CKSUM_EN -- after the last data byte, send
// one extra byte holding the modulo-2**DATA_W sum of the dumped bytes.
module ram_dump_ctrl
  import ram_dump_ctrl_pkg::*;
#(
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                DATA_W = DATA_W_DEF,
  parameter int                RD_LAT = RD_LAT_DEF,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key1,
  input  logic            key2,
  ram_dump_ctrl_if.master bus,
  output logic            state_led,
  output logic            busy
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        lat_cnt;
  logic              wr_go;
  logic              rd_go;
`ifdef RAM_DUMP_CKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  key_edge u_key1_edge (.clk(clk), .rst(rst), .level(key1), .pulse(wr_go));
  key_edge u_key2_edge (.clk(clk), .rst(rst), .level(key2), .pulse(rd_go));

  assign bus.ram_addr = addr;

  // Sequencer FSM with registered outputs; fill wins over dump on a tie.
  // NOTE: every register here uses <= so all branches see pre-edge values and
  // simulation matches the synthesized flops regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      lat_cnt       <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      state_led     <= 1'b0;
      busy          <= 1'b0;
`ifdef RAM_DUMP_CKSUM_EN
      sum           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr_go) begin
            state         <= FILL;
            addr          <= '0;
            bus.ram_we    <= 1'b1;
            bus.ram_wdata <= SEED;
            state_led     <= 1'b1;
            busy          <= 1'b1;
          end else if (rd_go) begin
            state     <= RD_ADDR;
            addr      <= '0;
            state_led <= 1'b1;
            busy      <= 1'b1;
`ifdef RAM_DUMP_CKSUM_EN
            sum       <= '0;
`endif
          end
        end

        FILL: begin
          if (addr == ADDR_LAST) begin
            state      <= IDLE;
            bus.ram_we <= 1'b0;
            state_led  <= 1'b0;
            busy       <= 1'b0;
          end else begin
            addr          <= addr + ADDR_W'(1);
            bus.ram_wdata <= DATA_W'(addr + ADDR_W'(1)) ^ SEED;
          end
        end

        RD_ADDR: begin
          state   <= RD_WAIT;
          lat_cnt <= '0;
        end

        RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state        <= TX_START;
            bus.tx_data  <= bus.ram_rdata;
            bus.tx_start <= 1'b1;
`ifdef RAM_DUMP_CKSUM_EN
            sum          <= sum + bus.ram_rdata;
`endif
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        TX_START: begin
          state        <= TX_WAIT;
          bus.tx_start <= 1'b0;
        end

        TX_WAIT: begin
          if (bus.tx_done) begin
            if (addr == ADDR_LAST) begin
`ifdef RAM_DUMP_CKSUM_EN
              state        <= CKSUM;
              bus.tx_data  <= sum;
              bus.tx_start <= 1'b1;
`else
              state     <= IDLE;
              state_led <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              state <= RD_ADDR;
              addr  <= addr + ADDR_W'(1);
            end
          end
        end

`ifdef RAM_DUMP_CKSUM_EN
        // Start pulse was issued on entry; wait for the checksum frame to end.
        CKSUM: begin
          bus.tx_start <= 1'b0;
          if (bus.tx_done && !bus.tx_start) begin
            state     <= IDLE;
            state_led <= 1'b0;
            busy      <= 1'b0;
          end
        end
`endif

        default: begin
          state        <= IDLE;
          bus.ram_we   <= 1'b0;
          bus.tx_start <= 1'b0;
          state_led    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Self-checking bench for ram_dump_ctrl with a synchronous RAM model
// (read latency 1), a UART model answering each tx_start with tx_done 20
// cycles later, and a reference image of the RAM contents.
`timescale 1ns/1ps
module tb_ram_dump_ctrl;
  import ram_dump_ctrl_pkg::*;

  localparam int         ADDR_W   = 8;
  localparam int         DATA_W   = 8;
  localparam int         DEPTH    = 256;
  localparam logic [7:0] SEED     = 8'h00;
  localparam int         UART_CYC = 20;
  localparam int         BUDGET   = 9000;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic key1;
  logic key2;
  logic state_led;
  logic busy;

  ram_dump_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_dump_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .key1(key1), .key2(key2),
    .bus(bus), .state_led(state_led), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: power-up contents come from init_val, then write-first-free
  // synchronous read with one cycle of latency.
  logic [7:0] init_val [DEPTH];
  logic [7:0] mem      [DEPTH];
  bit         ram_seeded = 1'b0;

  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
      ram_seeded <= 1'b1;
    end else begin
      if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // UART model: tx_done pulses exactly UART_CYC cycles after each tx_start.
  int uart_cnt = 0;
  always @(negedge clk) begin
    bus.tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) bus.tx_done = 1'b1;
    end
    if (bus.tx_start === 1'b1) uart_cnt = UART_CYC;
  end

  // Observed traffic, appended only.
  wr_t        wr_q [$];
  logic [7:0] tx_q [$];
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) wr_q.push_back('{bus.ram_addr, bus.ram_wdata});
    if (bus.tx_start === 1'b1) tx_q.push_back(bus.tx_data);
  end

  // Reference image of what the RAM should hold.
  logic [7:0] ref_mem [DEPTH];

  // Press keys, optionally press the other key mid-operation, and wait for
  // the operation to finish. Cycle numbers count negedges after the press.
  task automatic run_op(input bit p1, input bit p2, input int hold, input int intr_at,
                        input bit intr_key, output int first_we, output int last_we,
                        output int end_cyc);
    int cyc     = 0;
    bit started = 1'b0;
    first_we = -1;
    last_we  = -1;
    end_cyc  = -1;
    @(negedge clk);
    key1 = p1;
    key2 = p2;
    while (cyc < BUDGET && !(end_cyc >= 0 && cyc > intr_at + 3)) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) begin
        key1 = 1'b0;
        key2 = 1'b0;
      end
      if (intr_at > 0 && cyc == intr_at) begin
        if (intr_key) key1 = 1'b1;
        else          key2 = 1'b1;
      end
      if (intr_at > 0 && cyc == intr_at + 3) begin
        key1 = 1'b0;
        key2 = 1'b0;
      end
      if (bus.ram_we === 1'b1) begin
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (busy === 1'b1) started = 1'b1;
      else if (started && end_cyc < 0) end_cyc = cyc;
    end
    check("op_done", end_cyc >= 0, 1);
  endtask

  task automatic check_dump(input int base, input int n_data);
    logic [7:0] exp_q [$];
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < n_data; i++) begin
      exp_q.push_back(ref_mem[i]);
      sum += ref_mem[i];
    end
`ifdef RAM_DUMP_CKSUM_EN
    if (n_data == DEPTH) exp_q.push_back(sum);
`endif
    check("dump_count", tx_q.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      if (base + i < tx_q.size()) check("dump_byte", tx_q[base + i], exp_q[i]);
    end
  endtask

  task automatic do_fill(input bit both_keys, input int intr_at);
    int wb, tb0, first_we, last_we, end_cyc;
    wb  = wr_q.size();
    tb0 = tx_q.size();
    run_op(1'b1, both_keys, int'($urandom_range(1, 8)), intr_at, 1'b0,
           first_we, last_we, end_cyc);
    check("fill_count", wr_q.size() - wb, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (wb + i < wr_q.size()) begin
        check("fill_addr", wr_q[wb + i].addr, i);
        check("fill_data", wr_q[wb + i].data, 8'(i) ^ SEED);
      end
    end
    check("fill_no_tx", tx_q.size() - tb0, 0);
    check("fill_latency", first_we, 2);
    check("fill_busy_fall", end_cyc - last_we, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i) ^ SEED;
  endtask

  task automatic do_dump(input int intr_at);
    int wb, tb0, first_we, last_we, end_cyc;
    wb  = wr_q.size();
    tb0 = tx_q.size();
    run_op(1'b0, 1'b1, int'($urandom_range(1, 8)), intr_at, 1'b1,
           first_we, last_we, end_cyc);
    check_dump(tb0, DEPTH);
    check("dump_no_we", wr_q.size() - wb, 0);
  endtask

  initial begin
    int tb0, cnt, cyc;
    bit pick;

    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end

    // Reset with both keys held: outputs clear, no activity after release.
    rst  = 1'b1;
    key1 = 1'b1;
    key2 = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_we", bus.ram_we, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_led", state_led, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_writes", wr_q.size(), 0);
    check("post_rst_tx", tx_q.size(), 0);
    check("post_rst_busy", busy, 0);
    key1 = 1'b0;
    key2 = 1'b0;
    repeat (3) @(negedge clk);

    // Dump of the random power-up contents, key1 pressed mid-dump.
    do_dump(int'($urandom_range(20, 2000)));

    // Fill with key2 pressed mid-fill, then a dump with key1 pressed mid-dump.
    do_fill(1'b0, int'($urandom_range(12, 200)));
    do_dump(int'($urandom_range(20, 5000)));

    // Both keys rise together: fill only, then a dump on a later key2.
    do_fill(1'b1, 0);
    do_dump(0);

    // Reset after 100 bytes of a dump, then a fresh dump restarts at address 0.
    tb0 = tx_q.size();
    cnt = 0;
    cyc = 0;
    @(negedge clk);
    key2 = 1'b1;
    while (cnt < 100 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) key2 = 1'b0;
      if (bus.tx_start === 1'b1) cnt++;
    end
    check("abort_reached", cnt, 100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_led", state_led, 0);
    check("abort_tx_start", bus.tx_start, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_dump(tb0, 100);
    do_dump(0);

    // Randomized extra operations.
    for (int r = 0; r < 2; r++) begin
      pick = 1'($urandom_range(0, 1));
      if (pick) do_fill(1'b0, int'($urandom_range(12, 200)));
      else      do_dump(int'($urandom_range(20, 3000)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
